uart_rx_loader: RTL

UART_RX_LOADER -- requirements
Module: uart_rx_loader

---
 rtl/uart_rx_loader_if.sv | 12 +
 rtl/uart_rx_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader_if.sv
// Byte-memory write bus driven by uart_rx_loader into an SPRAM-style byte store.
interface uart_rx_loader_if;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_in;

  modport master (output mem_addr, output mem_write, output mem_data_in);
  modport slave  (input  mem_addr, input  mem_write, input  mem_data_in);
endinterface

// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that stores LOAD_LEN bytes into consecutive memory addresses, then stops.
// Optional stop-bit checking with frame_err pulse: define RX_FRAME_CHECK_EN.
module uart_rx_loader #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned LOAD_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  uart_rx_loader_if.master  mem,
  output logic              load_done,
  output logic              frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int unsigned TMR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned CNT_W        = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic              rx_meta_q, rxs_q, rxs_prev_q;
  logic [2:0]        state_q, state_n;
  logic [TMR_W-1:0]  tmr_q, tmr_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        shift_q, shift_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              wr_q, wr_n;
  logic [7:0]        dout_q, dout_n;
  logic              done_q, done_n;
`ifdef RX_FRAME_CHECK_EN
  logic              ferr_q, ferr_n;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      tmr_q   <= tmr_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      addr_q  <= addr_n;
      wr_q    <= wr_n;
      dout_q  <= dout_n;
      done_q  <= done_n;
`ifdef RX_FRAME_CHECK_EN
      ferr_q  <= ferr_n;
`endif
    end
  end

  // Next state; write strobe is raised on the stop-sample edge so it is high while in WRITE.
  always_comb begin
    state_n = state_q;
    tmr_n   = tmr_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    addr_n  = addr_q;
    wr_n    = 1'b0;
    dout_n  = dout_q;
    done_n  = done_q;
`ifdef RX_FRAME_CHECK_EN
    ferr_n  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_n = S_START;
          tmr_n   = '0;
        end
      end
      S_START: begin
        if (tmr_q == TMR_W'(HALF_BIT - 1)) begin
          tmr_n   = '0;
          bit_n   = '0;
          state_n = rxs_q ? S_IDLE : S_DATA;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_n   = '0;
          shift_n = {rxs_q, shift_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = S_STOP;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      S_STOP: begin
        if (tmr_q == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_n = '0;
`ifdef RX_FRAME_CHECK_EN
          if (!rxs_q) begin
            state_n = S_IDLE;
            ferr_n  = 1'b1;
          end else begin
            state_n = S_WRITE;
            wr_n    = 1'b1;
            dout_n  = shift_q;
          end
`else
          state_n = S_WRITE;
          wr_n    = 1'b1;
          dout_n  = shift_q;
`endif
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      S_WRITE: begin
        addr_n = addr_q + ADDR_W'(1);
        // Count compare is one bit wider so LOAD_LEN = 32768 terminates with addr wrapped to 0.
        if (CNT_W'(addr_q) + CNT_W'(1) == CNT_W'(LOAD_LEN)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem.mem_addr    = addr_q;
  assign mem.mem_write   = wr_q;
  assign mem.mem_data_in = dout_q;
  assign load_done       = done_q;
`ifdef RX_FRAME_CHECK_EN
  assign frame_err       = ferr_q;
`else
  assign frame_err       = 1'b0;
`endif

endmodule
